stallmem_mp: RTL and testbench

Parametrised, multi-port successor to the single-port stalling memory model used by the processor bench. It arbitrates `NUM_PORTS` requesters (e.g. port 0 = instruction fetch, port 1 = data) onto one word-addressed array. Each request completes after a configurable latency with a one-cycle `ready` pulse. It sits between `proc` and the bench clock/reset, and exercises processor stall handling under realistic contention.

---
 rtl/stallmem_pkg.sv | 24 ++
 rtl/stallmem_rr_arb.sv | 39 +++
 rtl/stallmem_mp.sv | 149 ++++++++++++++
 tb/tb_stallmem_mp.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/stallmem_pkg.sv
// stallmem_pkg: shared types and constants for the stallmem_mp memory model.
//   state_t     - controller FSM states (IDLE/BUSY/RESP)
//   LFSR_SEED   - reset value of the optional stall LFSR
//   LFSR_TAPS   - tap mask for x^16+x^14+x^13+x^11+1 (bits 15,13,12,10)
//   clog2()     - ceiling log2 for parameter arithmetic
package stallmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/stallmem_rr_arb.sv
// stallmem_rr_arb: combinational round-robin arbiter.
//   req  in  NUM_PORTS : request vector
//   last in  PW        : index of the most recently granted port
//   gnt  out NUM_PORTS : one-hot grant (all zero when no request)
//   idx  out PW        : index of the granted port
//   any  out 1         : at least one request present
// The search starts at last+1 and wraps, so a port that just won has the
// lowest priority on the next arbitration.
module stallmem_rr_arb
  import stallmem_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int PW        = 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PW-1:0]        last,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [PW-1:0]        idx,
  output logic                 any
);

  int p;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    p   = 0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      p = (int'(last) + i) % NUM_PORTS;
      if (!any && req[p]) begin
        any    = 1'b1;
        gnt[p] = 1'b1;
        idx    = PW'(p);
      end
    end
  end

endmodule

// File: rtl/stallmem_mp.sv
// stallmem_mp: multi-port stalling memory model. NUM_PORTS requesters are
// round-robin arbitrated onto one word array; one request is in flight at a
// time and each completes with a one-cycle ready pulse after LATENCY cycles.
//   clk, rst          : clock, asynchronous active-high reset
//   enable/wr         : per-port request and direction (1 = write)
//   addr/data_in      : flattened per-port byte address and write data
//   data_out/ready/err: flattened per-port registered response
// Optional build macro STALLMEM_RANDOM_STALL_EN: a 16-bit LFSR adds 0..3
// extra BUSY cycles per request.
module stallmem_mp
  import stallmem_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 1024,
  parameter int LATENCY   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          enable,
  input  logic [NUM_PORTS-1:0]          wr,
  input  logic [NUM_PORTS*ADDR_W-1:0]   addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   data_in,
  output logic [NUM_PORTS*DATA_W-1:0]   data_out,
  output logic [NUM_PORTS-1:0]          ready,
  output logic [NUM_PORTS-1:0]          err
);

  localparam int SH = clog2(DATA_W / 8);
  localparam int IW = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;
  localparam int PW = (clog2(NUM_PORTS) > 0) ? clog2(NUM_PORTS) : 1;
  localparam int CW = clog2(LATENCY + 4) + 1;
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((1 << SH) - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n, extra, total;
  logic [PW-1:0]     rr_ptr, port_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;

  logic [NUM_PORTS-1:0] gnt;
  logic [PW-1:0]        idx;
  logic                 any;

  stallmem_rr_arb #(.NUM_PORTS(NUM_PORTS), .PW(PW)) u_arb (
    .req  (enable),
    .last (rr_ptr),
    .gnt  (gnt),
    .idx  (idx),
    .any  (any)
  );

  // Granted port's request fields.
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              sel_wr, sel_err, accept;
  logic [IW-1:0]     sel_idx;

  always_comb begin
    sel_addr = addr[idx*ADDR_W +: ADDR_W];
    sel_data = data_in[idx*DATA_W +: DATA_W];
    sel_wr   = |(gnt & wr);
    // Misaligned, or word index past the array (covers nonzero upper bits).
    sel_err  = (|(sel_addr & LOW_MASK)) || ((sel_addr >> SH) >= DEPTH_A);
    sel_idx  = IW'(sel_addr >> SH);
    accept   = (state == IDLE) && any;
  end

`ifdef STALLMEM_RANDOM_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end

  assign extra = CW'(lfsr[1:0]);
`else
  assign extra = '0;
`endif

  // BUSY cycles still to spend after the accept edge.
  assign total = CW'(LATENCY - 1) + extra;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: if (any) begin
        if (total == '0) begin
          state_n = RESP;
        end else begin
          state_n = BUSY;
          cnt_n   = total;
        end
      end
      BUSY: begin
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) state_n = RESP;
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Response registers load during RESP, so the pulse is visible in the
  // following cycle, which is also the IDLE cycle that can take the next
  // accept: occupancy is LATENCY+1 cycles per request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rr_ptr   <= PW'(NUM_PORTS - 1);
      port_q   <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      ready    <= '0;
      err      <= '0;
      data_out <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      ready    <= '0;
      err      <= '0;
      data_out <= '0;
      if (accept) begin
        rr_ptr  <= idx;
        port_q  <= idx;
        err_q   <= sel_err;
        rdata_q <= (sel_err || sel_wr) ? '0 : mem[sel_idx];
      end
      if (state == RESP) begin
        ready[port_q]                       <= 1'b1;
        err[port_q]                         <= err_q;
        data_out[port_q*DATA_W +: DATA_W]   <= rdata_q;
      end
    end
  end

  // Array has no reset; writes commit at the accept edge.
  always_ff @(posedge clk) begin
    if (!rst && accept && sel_wr && !sel_err) mem[sel_idx] <= sel_data;
  end

endmodule

// File: tb/tb_stallmem_mp.sv
// tb_stallmem_mp: directed self-checking bench for stallmem_mp. A default
// instance (LATENCY=4) carries most tests; a LATENCY=1 instance covers the
// back-to-back case. Inputs are driven and outputs sampled on negedges.
module tb_stallmem_mp;
  localparam int NP = 2, DW = 32, AW = 32, DEPTH = 1024, LAT = 4;
`ifdef STALLMEM_RANDOM_STALL_EN
  localparam int EXTRA = 3;
`else
  localparam int EXTRA = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [NP-1:0]    enable, wr, ready, err;
  logic [NP*AW-1:0] addr;
  logic [NP*DW-1:0] data_in, data_out;
  logic [NP-1:0]    enable1, wr1, ready1, err1;
  logic [NP*AW-1:0] addr1;
  logic [NP*DW-1:0] data_in1, data_out1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stallmem_mp #(.NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr), .data_in(data_in),
    .data_out(data_out), .ready(ready), .err(err)
  );

  stallmem_mp #(.NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .enable(enable1), .wr(wr1), .addr(addr1), .data_in(data_in1),
    .data_out(data_out1), .ready(ready1), .err(err1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request on the default instance starting at a negedge while
  // it is IDLE; returns edges from accept to ready (-1 on timeout).
  task automatic do_req(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd, output logic re);
    enable[p] = 1'b1;
    wr[p] = w;
    addr[p*AW +: AW] = a;
    data_in[p*DW +: DW] = d;
    lat = -1;
    rd = 'x;
    re = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ready[p]) begin
        lat = i - 1;
        rd = data_out[p*DW +: DW];
        re = err[p];
        break;
      end
    end
    enable[p] = 1'b0;
  endtask

  task automatic req_check(input string tag, input int p, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] exp_d, input logic exp_e);
    int lat;
    logic [31:0] rd;
    logic re;
    do_req(p, w, a, d, lat, rd, re);
    check({tag, "_lat_ok"}, 64'(lat >= LAT && lat <= LAT + EXTRA), 64'd1);
    check({tag, "_data"}, 64'(rd), 64'(exp_d));
    check({tag, "_err"}, 64'(re), 64'(exp_e));
  endtask

  initial begin
    int ev_port [4];
    int ev_cyc [4];
    logic [31:0] ev_data [4];
    int nev, nrdy, lat, prev;
    logic [31:0] rd;
    logic re;
    logic [7:0] seen;

    rst = 1'b1;
    enable = '0; wr = '0; addr = '0; data_in = '0;
    enable1 = '0; wr1 = '0; addr1 = '0; data_in1 = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_dout", 64'(data_out), 64'd0);
    check("rst_ready1", 64'(ready1), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic write then read on port 0.
    req_check("wr10", 0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    req_check("rd10", 0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    req_check("wr14", 1, 1'b1, 32'h14, 32'hCAFEF00D, 32'h0, 1'b0);

    // Contention: both ports request from reset release.
    rst = 1'b1;
    enable = 2'b11; wr = 2'b00;
    addr = {32'h14, 32'h10};
    @(negedge clk);
    rst = 1'b0;
    nev = 0;
    for (int i = 1; i <= 40 && nev < 4; i++) begin
      @(negedge clk);
      if (|ready) begin
        ev_port[nev] = ready[1] ? 1 : 0;
        ev_cyc[nev]  = i - 1;
        ev_data[nev] = ready[1] ? data_out[DW +: DW] : data_out[0 +: DW];
        nev++;
      end
    end
    enable = '0;
    check("rr_events", 64'(nev), 64'd4);
    prev = 0;
    for (int k = 0; k < nev; k++) begin
      check($sformatf("rr_port%0d", k), 64'(ev_port[k]), 64'(k % 2));
      check($sformatf("rr_data%0d", k), 64'(ev_data[k]), (k % 2) ? 64'hCAFEF00D : 64'hDEADBEEF);
      check($sformatf("rr_gap%0d", k),
            64'((ev_cyc[k] - prev) >= ((k == 0) ? LAT : LAT + 1) &&
                (ev_cyc[k] - prev) <= ((k == 0) ? LAT : LAT + 1) + EXTRA), 64'd1);
      prev = ev_cyc[k];
    end
    @(negedge clk);

    // Error responses leave the array untouched.
    req_check("wr00", 1, 1'b1, 32'h0, 32'h12345678, 32'h0, 1'b0);
    req_check("wr_oor", 1, 1'b1, 32'h1000, 32'hFFFFFFFF, 32'h0, 1'b1);
    req_check("rd_mis", 1, 1'b0, 32'h6, 32'h0, 32'h0, 1'b1);
    req_check("rd_oor", 1, 1'b0, 32'h1000, 32'h0, 32'h0, 1'b1);
    req_check("rd_hi", 1, 1'b0, 32'h8000_0010, 32'h0, 32'h0, 1'b1);
    req_check("wr_mis", 1, 1'b1, 32'h12, 32'h00000055, 32'h0, 1'b1);
    req_check("rd00", 1, 1'b0, 32'h0, 32'h0, 32'h12345678, 1'b0);
    req_check("rd10b", 0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // LATENCY=1 instance: write, then hold a read request continuously.
    enable1[0] = 1'b1; wr1[0] = 1'b1; addr1[0 +: AW] = 32'h8; data_in1[0 +: DW] = 32'hA5A5A5A5;
    nrdy = 0;
    for (int i = 1; i <= 12 && nrdy == 0; i++) begin
      @(negedge clk);
      if (ready1[0]) nrdy++;
    end
    check("l1_wr_ready", 64'(nrdy), 64'd1);
    check("l1_wr_err", 64'(err1[0]), 64'd0);
    wr1[0] = 1'b0;
    nrdy = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
`ifndef STALLMEM_RANDOM_STALL_EN
      check($sformatf("l1_ready_c%0d", i), 64'(ready1[0]), 64'(i % 2 == 0));
`endif
      if (ready1[0]) begin
        nrdy++;
        check($sformatf("l1_data_c%0d", i), 64'(data_out1[0 +: DW]), 64'hA5A5A5A5);
      end
    end
    enable1 = '0;
    check("l1_nonzero", 64'(nrdy >= 1), 64'd1);
    @(negedge clk);
    @(negedge clk);

    // Reset in the middle of a read drops it.
    enable[0] = 1'b1; wr[0] = 1'b0; addr[0 +: AW] = 32'h10;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    enable = '0;
    #1;
    check("mid_rst_ready", 64'(ready), 64'd0);
    check("mid_rst_err", 64'(err), 64'd0);
    check("mid_rst_dout", 64'(data_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    nrdy = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (|ready) nrdy++;
    end
    check("mid_rst_no_ready", 64'(nrdy), 64'd0);
    req_check("post_rst_rd", 0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // Many reads: latency bounds and data; distinct latencies with stalls.
    seen = '0;
    for (int n = 0; n < 64; n++) begin
      do_req(n % 2, 1'b0, (n % 2) ? 32'h14 : 32'h10, 32'h0, lat, rd, re);
      check($sformatf("bulk_lat%0d", n), 64'(lat >= LAT && lat <= LAT + EXTRA), 64'd1);
      check($sformatf("bulk_data%0d", n), 64'(rd), (n % 2) ? 64'hCAFEF00D : 64'hDEADBEEF);
      if (lat >= 0 && lat < 8) seen[lat] = 1'b1;
    end
`ifdef STALLMEM_RANDOM_STALL_EN
    check("bulk_distinct", 64'($countones(seen) >= 2), 64'd1);
`else
    check("bulk_single_lat", 64'(seen), 64'(8'h1 << LAT));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
